// File: rtl/acc_ctrl_pkg.sv
// Shared opcode map, FSM encoding and default widths for the accumulator
// controller and its ALU.
package acc_ctrl_pkg;

  localparam int WORD_SIZE  = 8;
  localparam int INDEX_SIZE = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_STR  = 4'h1;
  localparam logic [3:0] OP_LDR  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_SWP  = 4'h9;
  localparam logic [3:0] OP_JMPR = 4'hA;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXEC   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Opcodes above JMPR are undefined.
  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_JMPR;
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational datapath for the accumulator: computes the new ACC value and
// flags for opcodes that update ACC during EXEC.
module acc_alu
  import acc_ctrl_pkg::*;
#(
  parameter int W = WORD_SIZE
) (
  input  logic [3:0]   i_op,
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_operand,
  input  logic         i_c,
  output logic [W-1:0] o_result,
  output logic         o_z,
  output logic         o_c,
  output logic         o_writes_acc
);

  logic [W:0] w_sum;
  logic [W:0] w_diff;

  // Bit W of the extended difference is the borrow (ACC < operand).
  assign w_sum  = {1'b0, i_acc} + {1'b0, i_operand};
  assign w_diff = {1'b0, i_acc} - {1'b0, i_operand};

  always_comb begin
    o_result     = i_acc;
    o_c          = i_c;
    o_writes_acc = 1'b0;
    case (i_op)
      OP_LDR, OP_LDI: begin
        o_result     = i_operand;
        o_writes_acc = 1'b1;
      end
      OP_ADD: begin
        o_result     = w_sum[W-1:0];
        o_c          = w_sum[W];
        o_writes_acc = 1'b1;
      end
      OP_SUB: begin
        o_result     = w_diff[W-1:0];
        o_c          = w_diff[W];
        o_writes_acc = 1'b1;
      end
      OP_AND: begin
        o_result     = i_acc & i_operand;
        o_c          = 1'b0;
        o_writes_acc = 1'b1;
      end
      OP_OR: begin
        o_result     = i_acc | i_operand;
        o_c          = 1'b0;
        o_writes_acc = 1'b1;
      end
      OP_XOR: begin
        o_result     = i_acc ^ i_operand;
        o_c          = 1'b0;
        o_writes_acc = 1'b1;
      end
      default: ;
    endcase
    o_z = (o_result == '0);
  end

endmodule

// File: rtl/acc_regfile_ctrl.sv
// Accumulator-side controller: accepts one instruction per handshake, drives
// the register file ports, holds ACC/Z/C and produces register-indirect jumps.
module acc_regfile_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int word_size  = WORD_SIZE,
  parameter int index_size = INDEX_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [7:0]            instr,
  input  logic [word_size-1:0]  imm,
  output logic                  rf_write_enable,
  output logic [index_size-1:0] rf_write_address,
  output logic [word_size-1:0]  rf_write_data,
  output logic [index_size-1:0] rf_read_address,
  input  logic [word_size-1:0]  rf_read_data,
  output logic [word_size-1:0]  acc,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic                  pc_load,
  output logic [word_size-1:0]  pc_target,
  output logic                  done,
  output logic                  illegal
);

  logic [1:0]            r_state;
  logic [3:0]            r_op;
  logic [index_size-1:0] r_rn;
  logic [word_size-1:0]  r_imm;
  logic [word_size-1:0]  r_acc;
  logic [word_size-1:0]  r_tmp;
  logic [word_size-1:0]  r_pc_target;
  logic                  r_z, r_c;
  logic                  r_done, r_pc_load, r_illegal;

  logic [word_size-1:0]  w_operand;
  logic [word_size-1:0]  w_alu_res;
  logic                  w_alu_z, w_alu_c, w_alu_wr;

  assign w_operand = (r_op == OP_LDI) ? r_imm : rf_read_data;

  acc_alu #(.W(word_size)) u_alu (
    .i_op         (r_op),
    .i_acc        (r_acc),
    .i_operand    (w_operand),
    .i_c          (r_c),
    .o_result     (w_alu_res),
    .o_z          (w_alu_z),
    .o_c          (w_alu_c),
    .o_writes_acc (w_alu_wr)
  );

  assign instr_ready      = (r_state == ST_IDLE);
  assign rf_write_enable  = (r_state == ST_EXEC) && ((r_op == OP_STR) || (r_op == OP_SWP));
  assign rf_write_address = r_rn;
  assign rf_read_address  = r_rn;
  assign rf_write_data    = r_acc;
  assign acc              = r_acc;
  assign flag_z           = r_z;
  assign flag_c           = r_c;
  assign pc_load          = r_pc_load;
  assign pc_target        = r_pc_target;
  assign done             = r_done;
  assign illegal          = r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NOP;
      r_rn        <= '0;
      r_imm       <= '0;
      r_acc       <= '0;
      r_tmp       <= '0;
      r_pc_target <= '0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_done      <= 1'b0;
      r_pc_load   <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_pc_load <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_op    <= instr[7:4];
            r_rn    <= instr[index_size-1:0];
            r_imm   <= imm;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_alu_wr) begin
            r_acc <= w_alu_res;
            r_z   <= w_alu_z;
            r_c   <= w_alu_c;
          end
          // SWP: the register file captures old ACC on this same edge.
          if (r_op == OP_SWP) begin
            r_tmp   <= rf_read_data;
            r_state <= ST_COMMIT;
          end else begin
            r_done    <= 1'b1;
            r_state   <= ST_IDLE;
            r_illegal <= op_illegal(r_op);
            if (r_op == OP_JMPR) begin
              r_pc_target <= rf_read_data;
              r_pc_load   <= 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          r_acc   <= r_tmp;
          r_z     <= (r_tmp == '0);
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_regfile_ctrl.sv
// Directed vector bench for acc_regfile_ctrl with a behavioural 16x8
// register file attached to its ports.
module tb_acc_regfile_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] instr = 8'h00;
  logic [7:0] imm = 8'h00;
  logic       rf_write_enable;
  logic [3:0] rf_write_address;
  logic [7:0] rf_write_data;
  logic [3:0] rf_read_address;
  logic [7:0] rf_read_data;
  logic [7:0] acc;
  logic       flag_z, flag_c, pc_load, done, illegal;
  logic [7:0] pc_target;

  logic [7:0] rf_mem [16];

  int n_vec = 0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rf_write_enable) rf_mem[rf_write_address] <= rf_write_data;
  assign rf_read_data = rf_mem[rf_read_address];

  acc_regfile_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr            (instr),
    .imm              (imm),
    .rf_write_enable  (rf_write_enable),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .rf_read_address  (rf_read_address),
    .rf_read_data     (rf_read_data),
    .acc              (acc),
    .flag_z           (flag_z),
    .flag_c           (flag_c),
    .pc_load          (pc_load),
    .pc_target        (pc_target),
    .done             (done),
    .illegal          (illegal)
  );

  typedef struct {
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] acc;
    logic       z;
    logic       c;
    logic       wr;
    logic [7:0] wd;
    int         lat;
    logic       ill;
    logic       pcl;
    logic [7:0] pct;
  } vec_t;

  vec_t tv[$];

  function automatic void v(input logic [7:0] i, input logic [7:0] im,
                            input logic [7:0] a, input logic z, input logic c,
                            input logic wr, input logic [7:0] wd, input int lat,
                            input logic ill, input logic pcl, input logic [7:0] pct);
    vec_t t;
    t.instr = i; t.imm = im; t.acc = a; t.z = z; t.c = c; t.wr = wr; t.wd = wd;
    t.lat = lat; t.ill = ill; t.pcl = pcl; t.pct = pct;
    tv.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic run(input vec_t t);
    int k, nwe;
    logic [3:0] wa;
    logic [7:0] wd;
    logic got;
    nwe = 0; wa = '0; wd = '0; got = 1'b0;
    n_vec++;
    chk("ready_before", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1; instr = t.instr; imm = t.imm;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = ~t.instr; imm = ~t.imm;
    k = 1;
    while (k < 8 && !got) begin
      @(negedge clk);
      if (rf_write_enable) begin
        nwe++; wa = rf_write_address; wd = rf_write_data;
      end
      if (done) got = 1'b1;
      else begin
        @(posedge clk);
        k++;
      end
    end
    if (!got) @(negedge clk);
    chk($sformatf("done_seen[%0h]", t.instr), 32'(got), 32'd1);
    chk($sformatf("latency[%0h]", t.instr), 32'(k), 32'(t.lat));
    chk($sformatf("ready_at_done[%0h]", t.instr), 32'(instr_ready), 32'd1);
    chk($sformatf("acc[%0h]", t.instr), 32'(acc), 32'(t.acc));
    chk($sformatf("z[%0h]", t.instr), 32'(flag_z), 32'(t.z));
    chk($sformatf("c[%0h]", t.instr), 32'(flag_c), 32'(t.c));
    chk($sformatf("illegal[%0h]", t.instr), 32'(illegal), 32'(t.ill));
    chk($sformatf("pc_load[%0h]", t.instr), 32'(pc_load), 32'(t.pcl));
    chk($sformatf("pc_target[%0h]", t.instr), 32'(pc_target), 32'(t.pct));
    chk($sformatf("we_cycles[%0h]", t.instr), 32'(nwe), t.wr ? 32'd1 : 32'd0);
    if (t.wr) begin
      chk($sformatf("wr_addr[%0h]", t.instr), 32'(wa), 32'(t.instr[3:0]));
      chk($sformatf("wr_data[%0h]", t.instr), 32'(wd), 32'(t.wd));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //  instr  imm    acc   z  c  wr wd    lat ill pcl pct
    v(8'h80, 8'h2A, 8'h2A, 0, 0, 0, 8'h00, 2, 0, 0, 8'h00); // LDI 2A
    v(8'h13, 8'h00, 8'h2A, 0, 0, 1, 8'h2A, 2, 0, 0, 8'h00); // STR R3
    v(8'h80, 8'h00, 8'h00, 1, 0, 0, 8'h00, 2, 0, 0, 8'h00); // LDI 0
    v(8'h23, 8'h00, 8'h2A, 0, 0, 0, 8'h00, 2, 0, 0, 8'h00); // LDR R3
    v(8'h80, 8'h20, 8'h20, 0, 0, 0, 8'h00, 2, 0, 0, 8'h00);
    v(8'h11, 8'h00, 8'h20, 0, 0, 1, 8'h20, 2, 0, 0, 8'h00); // R1=20
    v(8'h80, 8'h10, 8'h10, 0, 0, 0, 8'h00, 2, 0, 0, 8'h00);
    v(8'h12, 8'h00, 8'h10, 0, 0, 1, 8'h10, 2, 0, 0, 8'h00); // R2=10
    v(8'h80, 8'hF0, 8'hF0, 0, 0, 0, 8'h00, 2, 0, 0, 8'h00);
    v(8'h31, 8'h00, 8'h10, 0, 1, 0, 8'h00, 2, 0, 0, 8'h00); // ADD overflow
    v(8'h42, 8'h00, 8'h00, 1, 0, 0, 8'h00, 2, 0, 0, 8'h00); // SUB to zero
    v(8'h80, 8'h01, 8'h01, 0, 0, 0, 8'h00, 2, 0, 0, 8'h00);
    v(8'h14, 8'h00, 8'h01, 0, 0, 1, 8'h01, 2, 0, 0, 8'h00); // R4=01
    v(8'h80, 8'h00, 8'h00, 1, 0, 0, 8'h00, 2, 0, 0, 8'h00);
    v(8'h44, 8'h00, 8'hFF, 0, 1, 0, 8'h00, 2, 0, 0, 8'h00); // SUB borrow
    v(8'h80, 8'h3C, 8'h3C, 0, 1, 0, 8'h00, 2, 0, 0, 8'h00); // LDI keeps C
    v(8'h51, 8'h00, 8'h20, 0, 0, 0, 8'h00, 2, 0, 0, 8'h00); // AND
    v(8'h62, 8'h00, 8'h30, 0, 0, 0, 8'h00, 2, 0, 0, 8'h00); // OR
    v(8'h71, 8'h00, 8'h10, 0, 0, 0, 8'h00, 2, 0, 0, 8'h00); // XOR
    v(8'h72, 8'h00, 8'h00, 1, 0, 0, 8'h00, 2, 0, 0, 8'h00); // XOR to zero
    v(8'h00, 8'h77, 8'h00, 1, 0, 0, 8'h00, 2, 0, 0, 8'h00); // NOP
    v(8'h80, 8'hE0, 8'hE0, 0, 0, 0, 8'h00, 2, 0, 0, 8'h00);
    v(8'h31, 8'h00, 8'h00, 1, 1, 0, 8'h00, 2, 0, 0, 8'h00); // ADD wraps to 0
    v(8'hC0, 8'h55, 8'h00, 1, 1, 0, 8'h00, 2, 1, 0, 8'h00); // illegal
    v(8'hF3, 8'h55, 8'h00, 1, 1, 0, 8'h00, 2, 1, 0, 8'h00); // illegal
    v(8'h80, 8'h40, 8'h40, 0, 1, 0, 8'h00, 2, 0, 0, 8'h00);
    v(8'h17, 8'h00, 8'h40, 0, 1, 1, 8'h40, 2, 0, 0, 8'h00); // R7=40
    v(8'h80, 8'h55, 8'h55, 0, 1, 0, 8'h00, 2, 0, 0, 8'h00);
    v(8'hA7, 8'h00, 8'h55, 0, 1, 0, 8'h00, 2, 0, 1, 8'h40); // JMPR R7
    v(8'h80, 8'h99, 8'h99, 0, 1, 0, 8'h00, 2, 0, 0, 8'h40);
    v(8'h15, 8'h00, 8'h99, 0, 1, 1, 8'h99, 2, 0, 0, 8'h40); // R5=99
    v(8'h80, 8'h11, 8'h11, 0, 1, 0, 8'h00, 2, 0, 0, 8'h40);
    v(8'h95, 8'h00, 8'h99, 0, 1, 1, 8'h11, 3, 0, 0, 8'h40); // SWP R5
    v(8'h25, 8'h00, 8'h11, 0, 1, 0, 8'h00, 2, 0, 0, 8'h40); // R5 now 11
    v(8'h80, 8'h00, 8'h00, 1, 1, 0, 8'h00, 2, 0, 0, 8'h40);
    v(8'h95, 8'h00, 8'h11, 0, 1, 1, 8'h00, 3, 0, 0, 8'h40); // SWP with ACC=0
    v(8'h25, 8'h00, 8'h00, 1, 1, 0, 8'h00, 2, 0, 0, 8'h40); // LDR zero -> Z
    v(8'h80, 8'h22, 8'h22, 0, 1, 0, 8'h00, 2, 0, 0, 8'h40);

    // Reset state, with the input handshake held active during reset.
    instr_valid = 1'b1; instr = 8'h80; imm = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_z", 32'(flag_z), 32'd0);
    chk("rst_c", 32'(flag_c), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_we", 32'(rf_write_enable), 32'd0);
    chk("rst_done", 32'(done | pc_load | illegal), 32'd0);
    chk("rst_pct", 32'(pc_target), 32'd0);
    instr_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tv[i]) run(tv[i]);

    // Reset asserted while SWP R5 sits in COMMIT (ACC=22, R5=00).
    n_vec++;
    instr_valid = 1'b1; instr = 8'h95; imm = 8'h00;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 8'h00;
    @(posedge clk); #2;
    chk("commit_not_ready", 32'(instr_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(instr_ready), 32'd1);
    chk("midrst_acc", 32'(acc), 32'd0);
    chk("midrst_we", 32'(rf_write_enable), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("midrst_done_after", 32'(done), 32'd0);
    chk("midrst_acc_after", 32'(acc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // R5 received old ACC on the EXEC edge before the reset.
    run('{instr: 8'h25, imm: 8'h00, acc: 8'h22, z: 1'b0, c: 1'b0, wr: 1'b0,
          wd: 8'h00, lat: 2, ill: 1'b0, pcl: 1'b0, pct: 8'h00});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
